// File: rtl/fp_div_sequencer.sv
// FDIV.S sequencer: screens IEEE-754 specials, requests 1/|rs2| from the reciprocal
// unit, then multiplies, normalises (truncating) and hands the quotient out via valid/ready.
module fp_div_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_rs1_f,
  input  logic [31:0] i_rs2_f,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_err,
  output logic        o_recip_start,
  output logic [31:0] o_recip_operand,
  input  logic        i_recip_done,
  input  logic [31:0] i_recip_result
);

  typedef enum logic [2:0] {
    StIdle,
    StSpecial,
    StStart,
    StWait,
    StMult,
    StNorm,
    StDone
  } state_e;

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The incremented count reaching TIMEOUT_CYCLES-1 aborts, i.e. the old count is one less.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 2);
  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  state_e            state_q, state_d;
  logic [30:0]       rs1_q, rs1_d;
  logic [30:0]       rs2_q, rs2_d;
  logic              s_q, s_d;
  logic [30:0]       recip_q, recip_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [24:0]       p_q, p_d;
  logic signed [9:0] e_q, e_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;

  logic [7:0]  e1, e2, er;
  logic [22:0] m1, m2, mr;
  logic        z1, z2, inf1, inf2, nan1, nan2;
  logic        special_in;
  logic [47:0] prod;
  logic signed [9:0] e_mul, e_norm;
  logic [22:0] mant;
  logic [31:0] special_res, norm_res;
  logic        unused_bits;

  assign e1 = rs1_q[30:23];
  assign m1 = rs1_q[22:0];
  assign e2 = rs2_q[30:23];
  assign m2 = rs2_q[22:0];
  assign er = recip_q[30:23];
  assign mr = recip_q[22:0];

  // Denormals are screened as zeros.
  assign z1   = (e1 == 8'h00);
  assign z2   = (e2 == 8'h00);
  assign inf1 = (e1 == 8'hFF) && (m1 == 23'd0);
  assign inf2 = (e2 == 8'hFF) && (m2 == 23'd0);
  assign nan1 = (e1 == 8'hFF) && (m1 != 23'd0);
  assign nan2 = (e2 == 8'hFF) && (m2 != 23'd0);

  assign special_in = (i_rs1_f[30:23] == 8'h00) || (i_rs1_f[30:23] == 8'hFF) ||
                      (i_rs2_f[30:23] == 8'h00) || (i_rs2_f[30:23] == 8'hFF);

  always_comb begin
    special_res = {s_q, 31'd0};
    if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2)) begin
      special_res = QNaN;
    end else if (z2 || inf1) begin
      special_res = {s_q, 8'hFF, 23'd0};
    end else begin
      special_res = {s_q, 31'd0};
    end
  end

  assign prod  = {24'd0, 1'b1, m1} * {24'd0, 1'b1, mr};
  assign e_mul = $signed({2'b00, e1}) + $signed({2'b00, er}) - 10'sd127;

  // p_q holds product bits [47:23]; bit 24 is the carry-out position.
  assign mant   = p_q[24] ? p_q[23:1] : p_q[22:0];
  assign e_norm = e_q + (p_q[24] ? 10'sd1 : 10'sd0);

  always_comb begin
    norm_res = {s_q, e_norm[7:0], mant};
    if (e_norm >= 10'sd255) begin
      norm_res = {s_q, 8'hFF, 23'd0};
    end else if (e_norm <= 10'sd0) begin
      norm_res = {s_q, 31'd0};
    end
  end

  assign unused_bits = ^{prod[22:0], i_recip_result[31]};

  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    s_d      = s_q;
    recip_d  = recip_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    e_d      = e_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (i_valid) begin
          rs1_d   = i_rs1_f[30:0];
          rs2_d   = i_rs2_f[30:0];
          s_d     = i_rs1_f[31] ^ i_rs2_f[31];
          state_d = special_in ? StSpecial : StStart;
        end
      end
      StSpecial: begin
        result_d = special_res;
        err_d    = 1'b0;
        state_d  = StDone;
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (i_recip_done) begin
          recip_d = i_recip_result[30:0];
          state_d = StMult;
        end else if (cnt_q == CntLast) begin
          result_d = QNaN;
          err_d    = 1'b1;
          state_d  = StDone;
        end
      end
      StMult: begin
        p_d     = prod[47:23];
        e_d     = e_mul;
        state_d = StNorm;
      end
      StNorm: begin
        result_d = norm_res;
        err_d    = 1'b0;
        state_d  = StDone;
      end
      StDone: begin
        if (i_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      rs1_q    <= '0;
      rs2_q    <= '0;
      s_q      <= 1'b0;
      recip_q  <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      e_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      s_q      <= s_d;
      recip_q  <= recip_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      e_q      <= e_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign o_ready         = (state_q == StIdle);
  assign o_valid         = (state_q == StDone);
  assign o_recip_start   = (state_q == StStart);
  assign o_recip_operand = {1'b0, rs2_q};
  assign o_result        = result_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed bench for fp_div_sequencer with a behavioural reciprocal-unit responder.
module tb_fp_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_rs1_f;
  logic [31:0] i_rs2_f;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_err;
  logic        o_recip_start;
  logic [31:0] o_recip_operand;
  logic        i_recip_done;
  logic [31:0] i_recip_result;

  fp_div_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_rs1_f        (i_rs1_f),
    .i_rs2_f        (i_rs2_f),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .o_err          (o_err),
    .o_recip_start  (o_recip_start),
    .o_recip_operand(o_recip_operand),
    .i_recip_done   (i_recip_done),
    .i_recip_result (i_recip_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Responder: model_delay == 0 means never answer.
  int          model_delay = 0;
  logic [31:0] model_result = 32'd0;
  int          countdown = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] op_at_start = 32'd0;
  int          valid_cnt = 0;
  int          accept_cyc = 0;
  int          valid_cyc = 0;

  initial begin
    i_recip_done   = 1'b0;
    i_recip_result = 32'd0;
    forever begin
      @(negedge clk);
      i_recip_done = 1'b0;
      if (o_recip_start) begin
        start_cnt   = start_cnt + 1;
        start_cyc   = cyc;
        op_at_start = o_recip_operand;
        countdown   = model_delay;
      end else if (countdown > 0) begin
        countdown = countdown - 1;
        if (countdown == 0) begin
          i_recip_done   = 1'b1;
          i_recip_result = model_result;
          done_cyc       = cyc;
        end
      end
      if (o_valid) valid_cnt = valid_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    i_rs1_f = a;
    i_rs2_f = b;
    i_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        accept_cyc = cyc;
        break;
      end
    end
    check("accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with o_valid high.
  task automatic wait_valid(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_valid) begin
        ok = 1'b1;
        valid_cyc = cyc;
        break;
      end
    end
    check("valid_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_special(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                             input string tag);
    start_cnt = 0;
    issue(a, b);
    wait_valid(10);
    check(tag, o_result, exp);
    check({tag, "_lat"}, valid_cyc - accept_cyc, 32'd2);
    check({tag, "_nostart"}, start_cnt, 32'd0);
  endtask

  task automatic run_normal(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                            input logic [31:0] exp, input string tag);
    model_delay  = 5;
    model_result = r;
    start_cnt    = 0;
    issue(a, b);
    wait_valid(40);
    check(tag, o_result, exp);
    check({tag, "_err"}, {31'd0, o_err}, 32'd0);
    check({tag, "_lat"}, valid_cyc - done_cyc, 32'd3);
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_rs1_f = 32'd0;
    i_rs2_f = 32'd0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_start", {31'd0, o_recip_start}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_operand", o_recip_operand, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);

    // 6.0 / 2.0
    run_normal(32'h40C0_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, "div_6_2");
    check("div_6_2_starts", start_cnt, 32'd1);
    check("div_6_2_operand", op_at_start, 32'h4000_0000);

    // Product carry-out path: 3.0 * 1.5 = 4.5
    run_normal(32'h4040_0000, 32'h3F2A_AAAB, 32'h3FC0_0000, 32'h4090_0000, "carry");
    // Negative divisor: operand sent with sign stripped
    run_normal(32'h40C0_0000, 32'hC000_0000, 32'h3F00_0000, 32'hC040_0000, "neg_div");
    check("neg_div_operand", op_at_start, 32'h4000_0000);
    // Overflow to +inf
    run_normal(32'h7F00_0000, 32'h0080_0001, 32'h7EFF_FFFE, 32'h7F80_0000, "overflow");
    // Underflow flush to zero
    run_normal(32'h0080_0000, 32'h7E80_0000, 32'h0080_0000, 32'h0000_0000, "underflow");

    // Special cases
    model_delay = 5;
    run_special(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "one_div_zero");
    run_special(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
    run_special(32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, "zero_zero");
    run_special(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_inf");
    run_special(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, "neg_div_zero");
    run_special(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, "inf_div_x");
    run_special(32'h4040_0000, 32'h7F80_0000, 32'h0000_0000, "x_div_inf");
    run_special(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, "negzero_div_x");
    run_special(32'h3F80_0000, 32'h8000_0001, 32'hFF80_0000, "x_div_denorm");

    // Timeout
    model_delay = 0;
    start_cnt   = 0;
    issue(32'h3F80_0000, 32'h4040_0000);
    wait_valid(120);
    check("timeout_result", o_result, 32'h7FC0_0000);
    check("timeout_err", {31'd0, o_err}, 32'd1);
    check("timeout_lat", valid_cyc - start_cyc, 32'd64);
    check("timeout_starts", start_cnt, 32'd1);
    @(negedge clk);
    check("timeout_err_clr", {31'd0, o_err}, 32'd0);
    check("timeout_valid_clr", {31'd0, o_valid}, 32'd0);

    // Backpressure: -6.0 / 2.0 held for 3 cycles while a new operand waits
    model_delay  = 5;
    model_result = 32'h3F00_0000;
    @(posedge clk); #1;
    i_ready = 1'b0;
    issue(32'hC0C0_0000, 32'h4000_0000);
    wait_valid(40);
    @(posedge clk); #1;
    i_rs1_f = 32'h3F80_0000;
    i_rs2_f = 32'h0000_0000;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, o_valid}, 32'd1);
      check("bp_result", o_result, 32'hC040_0000);
      check("bp_ready", {31'd0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", {31'd0, o_valid}, 32'd0);
    check("bp_ready_back", {31'd0, o_ready}, 32'd1);
    accept_cyc = cyc;
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_valid(10);
    check("bp_next_result", o_result, 32'h7F80_0000);
    check("bp_next_lat", valid_cyc - accept_cyc, 32'd2);

    // Reset while waiting; the late done pulse must be ignored
    start_cnt = 0;
    issue(32'h40C0_0000, 32'h4000_0000);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (start_cnt != 0) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("rw_start_seen", {31'd0, seen}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_cnt = 0;
    @(negedge clk);
    check("rw_ready", {31'd0, o_ready}, 32'd1);
    check("rw_valid", {31'd0, o_valid}, 32'd0);
    check("rw_operand", o_recip_operand, 32'd0);
    check("rw_result", o_result, 32'd0);
    repeat (10) @(negedge clk);
    check("rw_no_output", valid_cnt, 32'd0);
    check("rw_ready_after", {31'd0, o_ready}, 32'd1);
    check("rw_starts", start_cnt, 32'd1);

    // Sequencer still usable after the abort
    run_normal(32'h40C0_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
